top3_candidate_selector: RTL and testbench
==========================================

Name: top3_candidate_selector

Overview:
- Sits directly upstream of the Viterbi decoder.
- Consumes one frame at a time from the gesture classifier: NUM_CLASS unsigned scores, streamed in class-index order.
- Keeps a running sorted top-3 (probability, char) list and presents the three best candidates on o_prob[0:2] / o_char[0:2].
- Pulses o_start on the first frame of a word and o_next on later frames, then stalls until the decoder acknowledges with its stepped pulse.

Parameters:
- NUM_CLASS, 27, scores per frame; class index = char code (0..25 letters, 26 space).
- PROB_W, 32, unsigned score/probability width.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_clear  input  1  synchronous abort of the current frame
- i_valid  input  1  i_score valid this cycle
- i_score  input  PROB_W  unsigned score of class index = internal counter
- i_new_word  input  1  sampled with the index-0 score; 1 = frame starts a new word
- i_ack  input  1  decoder finished consuming the candidates (driven by the Viterbi o_stepped)
- o_ready  output  1  score is accepted when i_valid & o_ready
- o_prob[0:2]  output  PROB_W each  top-3 scores, [0] highest
- o_char[0:2]  output  5 each  class indices matching o_prob
- o_start  output  1  one-cycle pulse: candidates valid, first frame of word
- o_next  output  1  one-cycle pulse: candidates valid, continuation frame

Behaviour:
- Reset values: state S_COLLECT, counter 0, slots invalid.
  - o_ready=1, o_prob all 0, o_char all 0, o_start=0, o_next=0, word flag 0.
- States:
  - S_COLLECT: o_ready=1. Each accepted score is inserted, then counter increments. Accepting index NUM_CLASS-1 -> S_EMIT.
  - S_EMIT: lasts exactly 1 cycle, o_ready=0. o_start=word_flag and o_next=~word_flag, exactly one of them asserted. -> S_WAIT.
  - S_WAIT: o_ready=0. When i_ack=1, the next cycle is S_COLLECT, counter=0 and all slots invalidated.
- Insertion: single cycle, three internal slots (valid, prob, char), sorted descending.
  - Invalid slots compare as "lower than anything".
  - If s > slot0 or slot0 invalid: shift 0->1->2, slot0=new.
  - Else if s > slot1 or slot1 invalid: slot1->slot2, slot1=new.
  - Else if s > slot2 or slot2 invalid: slot2=new.
  - Else the score is dropped.
  - Comparison is strict (>), so on ties the earlier (lower) index keeps the higher rank. A score of 0 still fills an invalid slot.
- Output registers: o_prob/o_char are loaded from the slots on the clock edge that enters S_EMIT.
  - Their values are stable during the o_start/o_next pulse and held until the next S_EMIT entry.
  - They are not affected by slot clearing, i_clear or new-frame collection.
- Latency: the pulse is asserted in the cycle after the edge that accepts the index NUM_CLASS-1 score.
- Word flag: latched from i_new_word on acceptance of index 0; ignored on all other indices.
- i_valid while o_ready=0: ignored; no counter change, no insertion.
- i_ack outside S_WAIT: ignored. The decoder must hold or repeat the ack; the block does not remember an early ack.
- i_clear (any state, priority over all else): next cycle S_COLLECT, counter 0, slots invalid, word flag 0, no pulse.
  - Output registers are held.
  - If i_clear and i_valid occur in the same cycle, the score is discarded.
- Counter is 5 bits and never wraps beyond NUM_CLASS-1.
- Asynchronous reset mid-frame: immediate return to the reset values above.

Test Plan:
- Scores 100+i for i=0..26, i_new_word=1 on index 0, no stalls -> 1 cycle after index 26: o_start=1, o_next=0; o_prob={126,125,124}, o_char={26,25,24}; o_ready=0 until i_ack.
- Second frame, i_new_word=0: score 500 at index 3, 400 at index 7, 300 at index 0, all others 10 -> o_next pulse only; o_prob={500,400,300}, o_char={3,7,0}.
- Ties: all 27 scores = 50 -> o_char={0,1,2}, o_prob={50,50,50}; all scores 0 -> o_char={0,1,2}, o_prob=0.
- Backpressure: hold i_valid=1 during S_EMIT/S_WAIT for 5 cycles before i_ack -> those scores ignored; the next frame starts at index 0 the cycle after the ack edge; o_prob stays at the old values until the next emit; an i_ack pulse during S_EMIT is ignored.
- Gapped input: random i_valid gaps within a frame -> same result as the first scenario.
- i_clear after index 12 of a frame -> no pulse; o_prob/o_char keep the previous frame's values; a full fresh frame then emits correctly. Asserting i_rst_n low mid-frame -> all outputs 0 and o_ready=1 immediately.

Source files
------------

// File: rtl/top3_candidate_selector_if.sv
// Classifier-side score stream and decoder-side candidate bundle.
// master drives scores/ack, slave (the selector) returns candidates.
interface top3_candidate_selector_if #(
  parameter int PROB_W = 32
);
  logic              i_clear;
  logic              i_valid;
  logic [PROB_W-1:0] i_score;
  logic              i_new_word;
  logic              i_ack;
  logic              o_ready;
  logic [PROB_W-1:0] o_prob [3];
  logic [4:0]        o_char [3];
  logic              o_start;
  logic              o_next;

  modport master (
    output i_clear, i_valid, i_score,
    output i_new_word, i_ack,
    input  o_ready, o_prob, o_char,
    input  o_start, o_next
  );

  modport slave (
    input  i_clear, i_valid, i_score,
    input  i_new_word, i_ack,
    output o_ready, o_prob, o_char,
    output o_start, o_next
  );
endinterface

// File: rtl/top3_candidate_selector.sv
// Streams one frame of class scores, keeps a sorted top-3 and hands it
// to the Viterbi decoder with an o_start/o_next pulse, then waits on i_ack.
module top3_candidate_selector #(
  parameter int NUM_CLASS = 27,
  parameter int PROB_W    = 32
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  top3_candidate_selector_if.slave bus
);
  typedef enum logic [1:0] {
    S_COLLECT,
    S_EMIT,
    S_WAIT
  } state_e;

  localparam logic [4:0] LAST = 5'(NUM_CLASS - 1);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        vld_q, vld_d;
  logic [PROB_W-1:0] prob_q [3];
  logic [PROB_W-1:0] prob_d [3];
  logic [4:0]        char_q [3];
  logic [4:0]        char_d [3];
  logic              word_q, word_d;
  logic [PROB_W-1:0] oprob_q [3];
  logic [PROB_W-1:0] oprob_d [3];
  logic [4:0]        ochar_q [3];
  logic [4:0]        ochar_d [3];
  logic [2:0]        gt;
  logic [2:0]        ins;

  // Invalid slots lose to any score, so a 0 still fills them.
  always_comb begin
    gt = '0;
    for (int i = 0; i < 3; i++) begin
      gt[i] = !vld_q[i] || (bus.i_score > prob_q[i]);
    end
    ins[0] = gt[0];
    ins[1] = !gt[0] && gt[1];
    ins[2] = !gt[0] && !gt[1] && gt[2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    prob_d  = prob_q;
    char_d  = char_q;
    word_d  = word_q;
    oprob_d = oprob_q;
    ochar_d = ochar_q;
    if (bus.i_clear) begin
      state_d = S_COLLECT;
      cnt_d   = '0;
      vld_d   = '0;
      word_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_COLLECT: begin
          if (bus.i_valid) begin
            if (cnt_q == '0) word_d = bus.i_new_word;
            unique case (1'b1)
              ins[0]: begin
                vld_d  = {vld_q[1:0], 1'b1};
                prob_d[2] = prob_q[1];
                prob_d[1] = prob_q[0];
                prob_d[0] = bus.i_score;
                char_d[2] = char_q[1];
                char_d[1] = char_q[0];
                char_d[0] = cnt_q;
              end
              ins[1]: begin
                vld_d[2]  = vld_q[1];
                vld_d[1]  = 1'b1;
                prob_d[2] = prob_q[1];
                prob_d[1] = bus.i_score;
                char_d[2] = char_q[1];
                char_d[1] = cnt_q;
              end
              ins[2]: begin
                vld_d[2]  = 1'b1;
                prob_d[2] = bus.i_score;
                char_d[2] = cnt_q;
              end
              default: ;
            endcase
            // Snapshot includes the final score's insertion.
            if (cnt_q == LAST) begin
              state_d = S_EMIT;
              oprob_d = prob_d;
              ochar_d = char_d;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        S_EMIT: state_d = S_WAIT;
        S_WAIT: begin
          if (bus.i_ack) begin
            state_d = S_COLLECT;
            cnt_d   = '0;
            vld_d   = '0;
          end
        end
        default: state_d = S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      vld_q   <= '0;
      word_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        prob_q[i]  <= '0;
        char_q[i]  <= '0;
        oprob_q[i] <= '0;
        ochar_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      word_q  <= word_d;
      prob_q  <= prob_d;
      char_q  <= char_d;
      oprob_q <= oprob_d;
      ochar_q <= ochar_d;
    end
  end

  assign bus.o_ready   = (state_q == S_COLLECT);
  assign bus.o_start   = (state_q == S_EMIT) && word_q;
  assign bus.o_next    = (state_q == S_EMIT) && !word_q;
  assign bus.o_prob[0] = oprob_q[0];
  assign bus.o_prob[1] = oprob_q[1];
  assign bus.o_prob[2] = oprob_q[2];
  assign bus.o_char[0] = ochar_q[0];
  assign bus.o_char[1] = ochar_q[1];
  assign bus.o_char[2] = ochar_q[2];
endmodule

// File: tb/tb_top3_candidate_selector.sv
// Scoreboard bench for top3_candidate_selector.
// Expected top-3 per frame is queued at drive time and popped on the pulse.
module tb_top3_candidate_selector;
  localparam int NC = 27;
  localparam int PW = 32;

  typedef struct {
    logic          start;
    logic [PW-1:0] p [3];
    logic [4:0]    c [3];
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  top3_candidate_selector_if #(.PROB_W(PW)) bus ();

  top3_candidate_selector #(
    .NUM_CLASS(NC),
    .PROB_W   (PW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] sc [NC];
  exp_t          q [$];
  exp_t          last_exp;

  // Reference: pick max three times, lowest index wins ties.
  function automatic exp_t model(input logic nw);
    exp_t e;
    bit   used [NC];
    int   best;
    for (int i = 0; i < NC; i++) used[i] = 1'b0;
    e.start = nw;
    for (int k = 0; k < 3; k++) begin
      best = -1;
      for (int i = 0; i < NC; i++) begin
        if (!used[i] && (best < 0 || sc[i] > sc[best])) best = i;
      end
      used[best] = 1'b1;
      e.p[k] = sc[best];
      e.c[k] = 5'(best);
    end
    return e;
  endfunction

  task automatic drive_scores(input int n, input bit nw, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(negedge clk);
          bus.i_valid = 1'b0;
          bus.i_score = $urandom;
        end
      end
      @(negedge clk);
      bus.i_valid    = 1'b1;
      bus.i_score    = sc[i];
      bus.i_new_word = (i == 0) ? nw : !nw;
    end
  endtask

  task automatic check_held(input string nm);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.o_prob[k] !== last_exp.p[k] || bus.o_char[k] !== last_exp.c[k]) begin
        errors++;
        $display("FAIL %s held[%0d] got %0d/%0d want %0d/%0d", nm, k,
                 bus.o_prob[k], bus.o_char[k], last_exp.p[k], last_exp.c[k]);
      end
    end
  endtask

  // Entered at the negedge of the cycle the pulse is due.
  task automatic check_emit(input string nm);
    int   n;
    exp_t e;
    n = 0;
    while (!(bus.o_start || bus.o_next) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s latency got %0d want 0", nm, n);
    end
    if (n >= 20) return;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected pulse got 1 want 0", nm);
      return;
    end
    e = q.pop_front();
    checks++;
    if (bus.o_start !== e.start || bus.o_next !== !e.start) begin
      errors++;
      $display("FAIL %s pulse got start=%b next=%b want start=%b", nm,
               bus.o_start, bus.o_next, e.start);
    end
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_emit got %b want 0", nm, bus.o_ready);
    end
    last_exp = e;
    check_held(nm);
    @(negedge clk);
    checks++;
    if (bus.o_start !== 1'b0 || bus.o_next !== 1'b0 || bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s after_pulse got s=%b n=%b r=%b want 0 0 0", nm,
               bus.o_start, bus.o_next, bus.o_ready);
    end
  endtask

  task automatic send_frame(input string nm, input bit nw, input bit gaps, input bit hold);
    q.push_back(model(nw));
    drive_scores(NC, nw, gaps);
    @(negedge clk);
    bus.i_valid = hold;
    bus.i_score = 32'hDEAD;
    bus.i_ack   = hold;
    check_emit(nm);
  endtask

  task automatic do_ack(input string nm);
    @(negedge clk);
    bus.i_ack = 1'b1;
    @(negedge clk);
    bus.i_ack = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_after_ack got %b want 1", nm, bus.o_ready);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_start !== 1'b0 || bus.o_next !== 1'b0) begin
      errors++;
      $display("FAIL %s ctrl got r=%b s=%b n=%b want 1 0 0", nm,
               bus.o_ready, bus.o_start, bus.o_next);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.o_prob[k] !== '0 || bus.o_char[k] !== '0) begin
        errors++;
        $display("FAIL %s out[%0d] got %0d/%0d want 0/0", nm, k,
                 bus.o_prob[k], bus.o_char[k]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_rel");
  endtask

  task automatic test_ascending();
    for (int i = 0; i < NC; i++) sc[i] = PW'(100 + i);
    send_frame("ascending", 1'b1, 1'b0, 1'b0);
    do_ack("ascending");
  endtask

  task automatic test_peaks();
    for (int i = 0; i < NC; i++) sc[i] = 10;
    sc[3] = 500;
    sc[7] = 400;
    sc[0] = 300;
    send_frame("peaks", 1'b0, 1'b0, 1'b0);
    do_ack("peaks");
  endtask

  task automatic test_ties();
    for (int i = 0; i < NC; i++) sc[i] = 50;
    send_frame("ties50", 1'b1, 1'b0, 1'b0);
    do_ack("ties50");
    for (int i = 0; i < NC; i++) sc[i] = 0;
    send_frame("ties0", 1'b0, 1'b0, 1'b0);
    do_ack("ties0");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NC; i++) sc[i] = $urandom;
    send_frame("bp", 1'b0, 1'b0, 1'b1);
    bus.i_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.o_ready !== 1'b0 || bus.o_start !== 1'b0 || bus.o_next !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall got r=%b s=%b n=%b want 0 0 0",
                 bus.o_ready, bus.o_start, bus.o_next);
      end
    end
    do_ack("bp");
    bus.i_valid = 1'b0;
    check_held("bp_hold");
    for (int i = 0; i < NC; i++) sc[i] = PW'(NC - i);
    send_frame("bp_next", 1'b1, 1'b0, 1'b0);
    do_ack("bp_next");
  endtask

  task automatic test_gapped();
    for (int i = 0; i < NC; i++) sc[i] = PW'(100 + i);
    send_frame("gapped", 1'b1, 1'b1, 1'b0);
    do_ack("gapped");
  endtask

  task automatic test_clear();
    for (int i = 0; i < NC; i++) sc[i] = PW'(1000 + i);
    drive_scores(13, 1'b1, 1'b0);
    @(negedge clk);
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_score = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.o_ready !== 1'b1 || bus.o_start !== 1'b0 || bus.o_next !== 1'b0) begin
        errors++;
        $display("FAIL clear_idle got r=%b s=%b n=%b want 1 0 0",
                 bus.o_ready, bus.o_start, bus.o_next);
      end
    end
    check_held("clear_hold");
    for (int i = 0; i < NC; i++) sc[i] = PW'((i * 7) % 11);
    send_frame("clear_fresh", 1'b0, 1'b0, 1'b0);
    do_ack("clear_fresh");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < NC; i++) sc[i] = PW'(200 + i);
    drive_scores(5, 1'b1, 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame("post_rst", 1'b0, 1'b0, 1'b0);
    do_ack("post_rst");
  endtask

  initial begin
    bus.i_clear    = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_score    = '0;
    bus.i_new_word = 1'b0;
    bus.i_ack      = 1'b0;
    test_reset();
    test_ascending();
    test_peaks();
    test_ties();
    test_back_to_back();
    test_gapped();
    test_clear();
    test_async_reset();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
